// File: rtl/lagarto0_pkg.sv
// Shared core package: address/line geometry plus instruction-cache refill
// types and constants.
package lagarto0_pkg;

  localparam int ADDR_SIZE           = 32;
  localparam int ICACHE_LINE_SIZE    = 32;
  localparam int ICACHE_OFF_BITS     = 2;
  localparam int ICACHE_REFILL_CNT_W = 32;

  // Clears the byte offset within a cache line.
  localparam logic [ADDR_SIZE-1:0] ILINE_ALIGN =
    ~ADDR_SIZE'((1 << ICACHE_OFF_BITS) - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FILL,
    REPLAY,
    ERR
  } refill_state_e;

endpackage

// File: rtl/icache_refill.sv
// Instruction cache miss/refill controller.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | tracking lookups; a registered miss stalls fetch
// REQ    | line request presented, waiting for mem_req_ready_i
// WAIT   | request accepted, waiting for the single response
// FILL   | one-cycle write of the returned line into the cache
// REPLAY | one-cycle re-read of the filled index before releasing fetch
// ERR    | bus error reported, held until the pipeline kills it
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   fetch_valid_i, pc_i, kill_i  fetch lookup and flush
//   hit_i                        cache hit for the previous cycle's lookup
//   cache_pc_o/we_o/inst_o       cache address and fill port
//   stall_o                      fetch hold
//   mem_req_*                    line request (valid/ready)
//   mem_rsp_*                    line response (no backpressure)
//   exc_o, exc_addr_o            instruction access fault
//   miss_cnt_o                   saturating miss counter
module icache_refill #(
  parameter int ADDR_SIZE = lagarto0_pkg::ADDR_SIZE,
  parameter int LINE_SIZE = lagarto0_pkg::ICACHE_LINE_SIZE,
  parameter int OFF_BITS  = 2,
  parameter int CNT_W     = lagarto0_pkg::ICACHE_REFILL_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fetch_valid_i,
  input  logic [ADDR_SIZE-1:0] pc_i,
  input  logic                 kill_i,
  input  logic                 hit_i,
  output logic [ADDR_SIZE-1:0] cache_pc_o,
  output logic                 cache_we_o,
  output logic [LINE_SIZE-1:0] cache_inst_o,
  output logic                 stall_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [ADDR_SIZE-1:0] mem_req_addr_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [LINE_SIZE-1:0] mem_rsp_data_i,
  input  logic                 mem_rsp_err_i,
  output logic                 exc_o,
  output logic [ADDR_SIZE-1:0] exc_addr_o,
  output logic [CNT_W-1:0]     miss_cnt_o
);
  import lagarto0_pkg::*;

  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ~ADDR_SIZE'((1 << OFF_BITS) - 1);

  refill_state_e        state_q;
  logic                 lookup_q;
  logic                 killed_q;
  logic [ADDR_SIZE-1:0] pc_q;
  logic [ADDR_SIZE-1:0] miss_addr_q;
  logic                 miss_det;

  // hit_i refers to the lookup registered in lookup_q/pc_q.
  assign miss_det   = (state_q == IDLE) & lookup_q & ~hit_i & ~kill_i;
  assign stall_o    = (state_q != IDLE) | miss_det;
  assign cache_pc_o = (state_q == FILL) ? miss_addr_q : pc_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      lookup_q        <= 1'b0;
      killed_q        <= 1'b0;
      pc_q            <= '0;
      miss_addr_q     <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      cache_we_o      <= 1'b0;
      cache_inst_o    <= '0;
      exc_o           <= 1'b0;
      exc_addr_o      <= '0;
      miss_cnt_o      <= '0;
    end else begin
      lookup_q <= fetch_valid_i & ~kill_i;
      pc_q     <= pc_i;

      case (state_q)
        IDLE: begin
          killed_q <= 1'b0;
          if (miss_det) begin
            miss_addr_q     <= pc_q & ALIGN_MASK;
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= pc_q & ALIGN_MASK;
            if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
            state_q <= REQ;
          end
        end

        // A kill here only marks the response for discard; the request
        // itself stays valid until accepted.
        REQ: begin
          if (kill_i) killed_q <= 1'b1;
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            state_q         <= WAIT;
          end
        end

        WAIT: begin
          if (mem_rsp_valid_i) begin
            if (killed_q | kill_i) begin
              killed_q <= 1'b0;
              state_q  <= IDLE;
            end else if (mem_rsp_err_i) begin
              exc_o      <= 1'b1;
              exc_addr_o <= miss_addr_q;
              state_q    <= ERR;
            end else begin
              cache_we_o   <= 1'b1;
              cache_inst_o <= mem_rsp_data_i;
              state_q      <= FILL;
            end
          end else if (kill_i) begin
            killed_q <= 1'b1;
          end
        end

        FILL: begin
          cache_we_o   <= 1'b0;
          cache_inst_o <= '0;
          state_q      <= REPLAY;
        end

        REPLAY: state_q <= IDLE;

        ERR: begin
          if (kill_i) begin
            exc_o   <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: a vector table for IDLE lookup
// behaviour plus hand-written miss, backpressure, kill, error and reset
// sequences.
module tb_icache_refill;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_valid_i;
  logic [31:0] pc_i;
  logic        kill_i;
  logic        hit_i;
  logic [31:0] cache_pc_o;
  logic        cache_we_o;
  logic [31:0] cache_inst_o;
  logic        stall_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        mem_rsp_err_i;
  logic        exc_o;
  logic [31:0] exc_addr_o;
  logic [31:0] miss_cnt_o;

  icache_refill dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fetch_valid_i  (fetch_valid_i),
    .pc_i           (pc_i),
    .kill_i         (kill_i),
    .hit_i          (hit_i),
    .cache_pc_o     (cache_pc_o),
    .cache_we_o     (cache_we_o),
    .cache_inst_o   (cache_inst_o),
    .stall_o        (stall_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i (mem_rsp_data_i),
    .mem_rsp_err_i  (mem_rsp_err_i),
    .exc_o          (exc_o),
    .exc_addr_o     (exc_addr_o),
    .miss_cnt_o     (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int hs_cnt = 0;
  int exp_cnt = 0;
  logic pending;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (cache_we_o) we_cnt <= we_cnt + 1;
      if (mem_req_valid_o && mem_req_ready_i) hs_cnt <= hs_cnt + 1;
    end
  end

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending <= 1'b0;
    else if (mem_req_valid_o && mem_req_ready_i) pending <= 1'b1;
    else if (mem_rsp_valid_i) pending <= 1'b0;
  end

  always @(posedge clk_i) begin
    if (!rst_i && mem_rsp_valid_i)
      assert (pending) else $error("FAIL rsp_protocol: response with no outstanding request");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_i);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Full miss with optional request backpressure and response latency.
  task automatic run_miss(input logic [31:0] p, input logic [31:0] d,
                          input int rdly, input int wdly);
    logic [31:0] a;
    int we0;
    int hs0;
    a   = p & 32'hFFFF_FFFC;
    we0 = we_cnt;
    hs0 = hs_cnt;
    cyc(); fetch_valid_i = 1; pc_i = p; hit_i = 1; mem_req_ready_i = (rdly == 0);
    cyc(); hit_i = 0;
    neg(); chk("miss_stall", stall_o, 1);
    chk("miss_no_req_yet", mem_req_valid_o, 0);
    cyc(); hit_i = 1;
    if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    neg(); chk("req_valid", mem_req_valid_o, 1);
    chk("req_addr", mem_req_addr_o, a);
    for (int i = 1; i <= rdly; i++) begin
      cyc();
      if (i == rdly) mem_req_ready_i = 1;
      neg(); chk("bp_valid_held", mem_req_valid_o, 1);
      chk("bp_addr_held", mem_req_addr_o, a);
    end
    cyc();
    neg(); chk("wait_valid_low", mem_req_valid_o, 0);
    chk("one_handshake", hs_cnt - hs0, 1);
    for (int i = 0; i < wdly; i++) begin
      cyc();
      neg(); chk("wait_stall", stall_o, 1);
    end
    cyc(); mem_rsp_valid_i = 1; mem_rsp_data_i = d; mem_rsp_err_i = 0;
    neg(); chk("no_early_we", cache_we_o, 0);
    cyc(); mem_rsp_valid_i = 0; mem_rsp_data_i = 0;
    neg(); chk("fill_we", cache_we_o, 1);
    chk("fill_data", cache_inst_o, d);
    chk("fill_pc", cache_pc_o, a);
    cyc();
    neg(); chk("replay_we_low", cache_we_o, 0);
    chk("replay_inst_zero", cache_inst_o, 0);
    chk("replay_stall", stall_o, 1);
    cyc();
    neg(); chk("release_stall", stall_o, 0);
    chk("miss_cnt", miss_cnt_o, exp_cnt);
    chk("one_fill", we_cnt - we0, 1);
  endtask

  typedef struct {
    logic        fv;
    logic        kill;
    logic        hit;
    logic [31:0] pc;
    logic        exp_stall;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int we0;

    // Each row's fv/kill form the lookup that the next row's hit answers.
    tbl[0]  = '{1, 0, 1, 32'h0000_0100, 0};
    for (int i = 1; i < 10; i++) tbl[i] = '{1, 0, 1, 32'h0000_0100 + 32'(4 * i), 0};
    tbl[10] = '{1, 1, 0, 32'h0000_0200, 0};  // miss masked by same-cycle kill
    tbl[11] = '{0, 0, 0, 32'h0000_0204, 0};  // previous lookup was killed
    tbl[12] = '{1, 0, 0, 32'h0000_0208, 0};  // no lookup last cycle
    tbl[13] = '{0, 1, 0, 32'h0000_020C, 0};  // kill masks the miss

    rst_i = 1; fetch_valid_i = 0; pc_i = 0; kill_i = 0; hit_i = 1;
    mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = 0; mem_rsp_err_i = 0;
    repeat (2) @(posedge clk_i);
    neg();
    chk("rst_stall", stall_o, 0);
    chk("rst_req_valid", mem_req_valid_o, 0);
    chk("rst_req_addr", mem_req_addr_o, 0);
    chk("rst_we", cache_we_o, 0);
    chk("rst_inst", cache_inst_o, 0);
    chk("rst_exc", exc_o, 0);
    chk("rst_exc_addr", exc_addr_o, 0);
    chk("rst_miss_cnt", miss_cnt_o, 0);
    cyc(); rst_i = 0;

    we0 = we_cnt;
    for (int i = 0; i < 14; i++) begin
      cyc();
      fetch_valid_i = tbl[i].fv; kill_i = tbl[i].kill; hit_i = tbl[i].hit; pc_i = tbl[i].pc;
      neg();
      chk("tbl_stall", stall_o, tbl[i].exp_stall);
      chk("tbl_cache_pc", cache_pc_o, tbl[i].pc);
      chk("tbl_req_valid", mem_req_valid_o, 0);
      chk("tbl_we", cache_we_o, 0);
    end
    kill_i = 0; hit_i = 1;
    chk("hits_miss_cnt", miss_cnt_o, 0);
    chk("hits_no_fill", we_cnt - we0, 0);

    // Cold miss, then backpressure with an unaligned pc.
    run_miss(32'h0000_0400, 32'hDEAD_BEEF, 0, 2);
    run_miss(32'h0000_0123, 32'hA5A5_0001, 5, 1);

    // Kill while the request is still waiting for ready.
    we0 = we_cnt;
    cyc(); fetch_valid_i = 1; pc_i = 32'h0000_0600; hit_i = 1; mem_req_ready_i = 0;
    cyc(); hit_i = 0;
    cyc(); hit_i = 1; exp_cnt++;
    neg(); chk("kreq_valid", mem_req_valid_o, 1);
    cyc(); kill_i = 1;
    neg(); chk("kreq_valid_held", mem_req_valid_o, 1);
    chk("kreq_stall", stall_o, 1);
    cyc(); kill_i = 0; mem_req_ready_i = 1;
    neg(); chk("kreq_valid_still", mem_req_valid_o, 1);
    cyc();
    neg(); chk("kreq_wait", mem_req_valid_o, 0);
    cyc(); mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h1234_5678;
    cyc(); mem_rsp_valid_i = 0; mem_rsp_data_i = 0;
    neg(); chk("kreq_no_we", cache_we_o, 0);
    chk("kreq_stall_released", stall_o, 0);

    // Kill while waiting for the response.
    cyc(); pc_i = 32'h0000_0700; hit_i = 1;
    cyc(); hit_i = 0;
    cyc(); hit_i = 1; exp_cnt++;
    cyc();
    neg(); chk("kwait_in_wait", mem_req_valid_o, 0);
    cyc(); kill_i = 1;
    cyc(); kill_i = 0;
    neg(); chk("kwait_stall", stall_o, 1);
    cyc(); mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h1234_5678;
    cyc(); mem_rsp_valid_i = 0; mem_rsp_data_i = 0;
    neg(); chk("kwait_no_we", cache_we_o, 0);
    chk("kwait_stall_released", stall_o, 0);
    chk("kill_no_fills", we_cnt - we0, 0);
    chk("kill_miss_cnt", miss_cnt_o, exp_cnt);

    // Discard flag must be clear: the next miss fills normally.
    run_miss(32'h0000_0704, 32'hCAFE_F00D, 0, 0);

    // Bus error.
    we0 = we_cnt;
    cyc(); pc_i = 32'h0000_0808; hit_i = 1; mem_req_ready_i = 1;
    cyc(); hit_i = 0;
    cyc(); hit_i = 1; exp_cnt++;
    cyc();
    cyc(); mem_rsp_valid_i = 1; mem_rsp_err_i = 1; mem_rsp_data_i = 32'hBAD0_BAD0;
    cyc(); mem_rsp_valid_i = 0; mem_rsp_err_i = 0; mem_rsp_data_i = 0;
    neg(); chk("err_exc", exc_o, 1);
    chk("err_exc_addr", exc_addr_o, 32'h0000_0808);
    chk("err_stall", stall_o, 1);
    chk("err_no_we", cache_we_o, 0);
    cyc(); cyc();
    neg(); chk("err_exc_held", exc_o, 1);
    chk("err_stall_held", stall_o, 1);
    cyc(); kill_i = 1;
    neg(); chk("err_exc_kill_cycle", exc_o, 1);
    cyc(); kill_i = 0;
    neg(); chk("err_exc_cleared", exc_o, 0);
    chk("err_stall_released", stall_o, 0);
    chk("err_no_fill", we_cnt - we0, 0);

    // Asynchronous reset while waiting for a response.
    cyc(); pc_i = 32'h0000_0900; hit_i = 1;
    cyc(); hit_i = 0;
    cyc(); hit_i = 1;
    cyc();
    neg(); chk("rstw_in_wait", stall_o, 1);
    rst_i = 1; exp_cnt = 0;
    #1;
    chk("rstw_stall", stall_o, 0);
    chk("rstw_req_valid", mem_req_valid_o, 0);
    chk("rstw_we", cache_we_o, 0);
    chk("rstw_exc", exc_o, 0);
    chk("rstw_miss_cnt", miss_cnt_o, 0);
    cyc(); rst_i = 0;
    run_miss(32'h0000_0A00, 32'h0BAD_CAFE, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
